// File: rtl/sram_sweep.sv
// sram_sweep: walks every address of an asynchronous SRAM once per request,
// either writing a caller-supplied data stream or reading the array back.
// Each address takes three clocks; one DONE clock with a stop pulse closes
// the sweep.
//
// Ports
//   clk        single system clock
//   rst_n      asynchronous active-low reset
//   start      sweep request, honoured only while idle
//   rnw        sweep direction, sampled with start (1 = read, 0 = write)
//   wdat       write data for the current address, advanced by the source on ready
//   ready      one-clock pulse per address (wdat consumed / rdat valid)
//   rdat       registered read data, held until the next read sample
//   stop       one-clock pulse at the end of a sweep
//   SRAM_DQ    bidirectional SRAM data, driven only in write states
//   SRAM_ADDR  registered SRAM address (the sweep counter itself)
//   SRAM_CE_N  chip enable, active low, registered
//   SRAM_OE_N  output enable, active low, registered
//   SRAM_WE_N  write enable, active low, registered
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; strobes inactive, DQ released
// W_SETUP  | address and write data presented, chip enabled
// W_PULSE  | write enable asserted
// W_HOLD   | write enable released, data still driven; ready pulse
// R_ADDR   | address presented, chip and output enabled
// R_WAIT   | access time; DQ is captured at the end of this state
// R_SAMPLE | captured data on rdat; ready pulse
// DONE     | one clock, strobes inactive; stop pulse

module sram_sweep #(
  parameter int SRAM_DATA_SIZE = 8,
  parameter int SRAM_ADDR_SIZE = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      rnw,
  input  logic [SRAM_DATA_SIZE-1:0] wdat,
  output logic                      ready,
  output logic [SRAM_DATA_SIZE-1:0] rdat,
  output logic                      stop,
  inout  wire  [SRAM_DATA_SIZE-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_ADDR   = 3'd4,
    R_WAIT   = 3'd5,
    R_SAMPLE = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [SRAM_ADDR_SIZE-1:0] CNT_LAST = '1;
  localparam logic [SRAM_ADDR_SIZE-1:0] CNT_ONE  = {{(SRAM_ADDR_SIZE-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic [SRAM_ADDR_SIZE-1:0]   cnt_q, cnt_d;
  logic [SRAM_DATA_SIZE-1:0]   wdat_q, wdat_d;
  logic [SRAM_DATA_SIZE-1:0]   rdat_q, rdat_d;
  logic                        ready_q, ready_d;
  logic                        stop_q, stop_d;
  logic                        ce_n_q, ce_n_d;
  logic                        oe_n_q, oe_n_d;
  logic                        we_n_q, we_n_d;
  logic                        dq_oe_q, dq_oe_d;

  // Next-state and counter. The counter doubles as the registered address,
  // so it only advances on the transition into the next access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = rnw ? R_ADDR : W_SETUP;
        end
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: state_d = W_HOLD;
      W_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = W_SETUP;
        end
      end
      R_ADDR: state_d = R_WAIT;
      R_WAIT: state_d = R_SAMPLE;
      R_SAMPLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = R_ADDR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every strobe
  // changes cleanly on the clock edge that enters the state it belongs to.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ready_d = 1'b0;
    stop_d  = 1'b0;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    unique case (state_d)
      W_SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      W_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      W_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        ready_d = 1'b1;
      end
      R_ADDR, R_WAIT: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      R_SAMPLE: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        ready_d = 1'b1;
      end
      DONE:    stop_d = 1'b1;
      default: ;
    endcase
    // Write data is latched once per address so the source may advance on ready.
    if (state_d == W_SETUP && state_q != W_SETUP) begin
      wdat_d = wdat;
    end
    // The edge leaving R_WAIT samples the bus after two clocks of access time.
    if (state_q == R_WAIT) begin
      rdat_d = SRAM_DQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ready_q <= 1'b0;
      stop_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ready_q <= ready_d;
      stop_q  <= stop_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? wdat_q : {SRAM_DATA_SIZE{1'bz}};
  assign SRAM_ADDR = cnt_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign ready     = ready_q;
  assign stop      = stop_q;
  assign rdat      = rdat_q;

endmodule

// File: tb/tb_sram_sweep.sv
// tb_sram_sweep: directed bench for sram_sweep with an 8-location SRAM model.
module tb_sram_sweep;

  localparam int D = 8;
  localparam int A = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         rnw;
  logic [D-1:0] wdat;
  logic         ready;
  logic [D-1:0] rdat;
  logic         stop;
  wire  [D-1:0] dq;
  logic [A-1:0] addr;
  logic         ce_n;
  logic         oe_n;
  logic         we_n;

  int vectors;
  int miscompares;

  logic [D-1:0] mem     [0:7];
  logic [D-1:0] exp_mem [0:7];

  sram_sweep #(.SRAM_DATA_SIZE(D), .SRAM_ADDR_SIZE(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rnw       (rnw),
    .wdat      (wdat),
    .ready     (ready),
    .rdat      (rdat),
    .stop      (stop),
    .SRAM_DQ   (dq),
    .SRAM_ADDR (addr),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  // Behavioural asynchronous SRAM.
  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : {D{1'bz}};
  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[addr] <= dq;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || stop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: ready=%b stop=%b, required 0 0", ready, stop);
    end
    vectors++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_strobes: ce_n=%b oe_n=%b we_n=%b, required 1 1 1", ce_n, oe_n, we_n);
    end
    vectors++;
    if (addr !== 3'd0 || rdat !== 8'h00 || dut.dq_oe_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs: addr=%0d rdat=%h dq_oe=%b, required 0 00 0", addr, rdat, dut.dq_oe_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (ce_n !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: ce_n=%b ready=%b, required 1 0", ce_n, ready);
    end
  endtask

  // Write sweep of base+n. With pulse_start, start toggles through the sweep
  // and is high in the DONE cycle; none of it may restart or extend the sweep.
  task automatic test_write_sweep(input logic [D-1:0] base, input bit pulse_start);
    int nwr = 0;
    int nrdy = 0;
    int nstop = 0;
    int stop_k = -1;
    start = 1'b1;
    rnw   = 1'b0;
    wdat  = base;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (pulse_start && k <= 25) ? k[0] : 1'b0;
      rnw   = k[1];
      vectors++;
      if (ready && stop) begin
        miscompares++;
        $display("FAIL wr_ready_stop k=%0d: ready=%b stop=%b, required not both", k, ready, stop);
      end
      vectors++;
      if (!oe_n && dut.dq_oe_q) begin
        miscompares++;
        $display("FAIL wr_dq_contention k=%0d: oe_n=0 with DQ driven", k);
      end
      if (!we_n) begin
        vectors++;
        if (addr !== nwr[A-1:0] || dq !== base + nwr[D-1:0] || k != 3 * nwr + 2) begin
          miscompares++;
          $display("FAIL wr_pulse%0d: k=%0d addr=%0d dq=%h, required k=%0d addr=%0d dq=%h",
                   nwr, k, addr, dq, 3 * nwr + 2, nwr, base + nwr[D-1:0]);
        end
        nwr++;
      end
      if (ready) begin
        nrdy++;
        wdat = base + nrdy[D-1:0];
      end
      if (stop) begin
        nstop++;
        if (stop_k < 0) stop_k = k;
      end
    end
    vectors++;
    if (nwr != 8 || nrdy != 8) begin
      miscompares++;
      $display("FAIL wr_counts: we pulses=%0d ready=%0d, required 8 8", nwr, nrdy);
    end
    vectors++;
    if (stop_k != 25 || nstop != 1) begin
      miscompares++;
      $display("FAIL wr_stop: at clock %0d count %0d, required 25 1", stop_k, nstop);
    end
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = base + i[D-1:0];
      vectors++;
      if (mem[i] !== exp_mem[i]) begin
        miscompares++;
        $display("FAIL wr_mem[%0d]: got %h, required %h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_read_sweep();
    int nrdy = 0;
    int nstop = 0;
    int stop_k = -1;
    int last_rdy_k = -1;
    start = 1'b1;
    rnw   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      rnw   = 1'b0;
      vectors++;
      if (ready && stop) begin
        miscompares++;
        $display("FAIL rd_ready_stop k=%0d: ready=%b stop=%b, required not both", k, ready, stop);
      end
      vectors++;
      if (!oe_n && dut.dq_oe_q) begin
        miscompares++;
        $display("FAIL rd_dq_contention k=%0d: oe_n=0 with DQ driven", k);
      end
      if (k <= 24 && (k - 1) % 3 == 0) begin
        vectors++;
        if (addr !== 3'((k - 1) / 3) || ce_n !== 1'b0 || oe_n !== 1'b0 || we_n !== 1'b1) begin
          miscompares++;
          $display("FAIL rd_addr k=%0d: addr=%0d ce_n=%b oe_n=%b we_n=%b, required %0d 0 0 1",
                   k, addr, ce_n, oe_n, we_n, (k - 1) / 3);
        end
      end
      if (ready) begin
        vectors++;
        if (nrdy > 7 || rdat !== exp_mem[nrdy & 7] || k != 3 * nrdy + 3) begin
          miscompares++;
          $display("FAIL rd_data%0d: k=%0d rdat=%h, required k=%0d rdat=%h",
                   nrdy, k, rdat, 3 * nrdy + 3, exp_mem[nrdy & 7]);
        end
        nrdy++;
        last_rdy_k = k;
      end
      if (stop) begin
        nstop++;
        if (stop_k < 0) stop_k = k;
      end
    end
    vectors++;
    if (nrdy != 8 || nstop != 1 || stop_k != 25 || stop_k != last_rdy_k + 1) begin
      miscompares++;
      $display("FAIL rd_sweep: ready=%0d stops=%0d stop_at=%0d last_ready=%0d, required 8 1 25 24",
               nrdy, nstop, stop_k, last_rdy_k);
    end
    vectors++;
    if (rdat !== exp_mem[7]) begin
      miscompares++;
      $display("FAIL rd_hold: rdat=%h, required %h", rdat, exp_mem[7]);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int nstop = 0;
    int nrdy = 0;
    bit hit = 1'b0;
    start = 1'b1;
    rnw   = 1'b0;
    wdat  = 8'hC0;
    while (!hit && k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (stop) nstop++;
      if (ready) begin
        nrdy++;
        wdat = 8'hC0 + nrdy[D-1:0];
      end
      if (!we_n && addr == 3'd4) hit = 1'b1;
    end
    vectors++;
    if (!hit || k != 14) begin
      miscompares++;
      $display("FAIL mid_reach: W_PULSE at address 4 seen=%b at clock %0d, required 1 at 14", hit, k);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || dut.dq_oe_q !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_strobes: ce_n=%b oe_n=%b we_n=%b dq_oe=%b, required 1 1 1 0",
               ce_n, oe_n, we_n, dut.dq_oe_q);
    end
    vectors++;
    if (ready !== 1'b0 || stop !== 1'b0 || addr !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_regs: ready=%b stop=%b addr=%0d, required 0 0 0", ready, stop, addr);
    end
    repeat (3) begin
      @(negedge clk);
      if (stop) nstop++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (stop) nstop++;
    end
    vectors++;
    if (nstop != 0) begin
      miscompares++;
      $display("FAIL mid_no_stop: stop pulses=%0d, required 0", nstop);
    end
    for (int i = 0; i < 4; i++) exp_mem[i] = 8'hC0 + i[D-1:0];
    test_read_sweep();
  endtask

  task automatic test_back_to_back();
    int nstop = 0;
    int nrdy = 0;
    int stop_k [2] = '{-1, -1};
    start = 1'b1;
    rnw   = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      vectors++;
      if (ready && stop) begin
        miscompares++;
        $display("FAIL b2b_ready_stop k=%0d: ready=%b stop=%b, required not both", k, ready, stop);
      end
      vectors++;
      if (!oe_n && dut.dq_oe_q) begin
        miscompares++;
        $display("FAIL b2b_dq_contention k=%0d: oe_n=0 with DQ driven", k);
      end
      if (k == 26) begin
        vectors++;
        if (ce_n !== 1'b1 || ready !== 1'b0 || stop !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle: ce_n=%b ready=%b stop=%b, required 1 0 0", ce_n, ready, stop);
        end
      end
      if (k == 27) begin
        vectors++;
        if (oe_n !== 1'b0 || addr !== 3'd0) begin
          miscompares++;
          $display("FAIL b2b_restart: oe_n=%b addr=%0d, required 0 0", oe_n, addr);
        end
      end
      if (ready) begin
        vectors++;
        if (rdat !== exp_mem[nrdy & 7]) begin
          miscompares++;
          $display("FAIL b2b_data%0d: rdat=%h, required %h", nrdy, rdat, exp_mem[nrdy & 7]);
        end
        nrdy++;
      end
      if (stop) begin
        if (nstop < 2) stop_k[nstop] = k;
        nstop++;
        if (nstop == 2) start = 1'b0;
      end
    end
    vectors++;
    if (nstop != 2 || stop_k[0] != 25 || stop_k[1] != 51 || nrdy != 16) begin
      miscompares++;
      $display("FAIL b2b_timing: stops=%0d at %0d,%0d ready=%0d, required 2 at 25,51 ready=16",
               nstop, stop_k[0], stop_k[1], nrdy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    rnw   = 1'b0;
    wdat  = '0;
    test_reset();
    test_write_sweep(8'hA0, 1'b0);
    test_read_sweep();
    test_write_sweep(8'h50, 1'b1);
    test_read_sweep();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_sweep.md
SRAM_SWEEP -- requirements
Module: sram_sweep

Interface
REQ-001 Parameter SRAM_DATA_SIZE, default 8, SRAM data bus width.
REQ-002 Parameter SRAM_ADDR_SIZE, default 19, SRAM address width; one sweep covers 2**SRAM_ADDR_SIZE locations.
REQ-003 clk  input  1  single clock for all logic; one clock domain.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  sweep request, sampled high in IDLE only.
REQ-006 rnw  input  1  sweep direction, sampled with start: 1 = read sweep, 0 = write sweep.
REQ-007 wdat  input  SRAM_DATA_SIZE  write data for the current address.
REQ-008 ready  output  1  one-clock pulse per address: wdat consumed (write) or rdat valid (read).
REQ-009 rdat  output  SRAM_DATA_SIZE  registered read data.
REQ-010 stop  output  1  one-clock pulse at the end of a sweep.
REQ-011 SRAM_DQ  inout  SRAM_DATA_SIZE  SRAM data; driven only during write states, else high-Z.
REQ-012 SRAM_ADDR  output  SRAM_ADDR_SIZE  registered SRAM address.
REQ-013 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes, all registered.

Function
REQ-014 FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_WAIT, R_SAMPLE, DONE.
REQ-015 IDLE: start=1 captures rnw and clears address counter to 0; next state W_SETUP (rnw=0) or R_ADDR (rnw=1); start=0 stays IDLE.
REQ-016 start in any state other than IDLE is ignored; rnw is ignored outside the start sample.
REQ-017 Write access takes 3 clocks per address. W_SETUP: SRAM_ADDR=counter, DQ driven with wdat captured on entry, CE_N=0, WE_N=1, OE_N=1. W_PULSE: WE_N=0. W_HOLD: WE_N=1, DQ still driven, ready=1.
REQ-018 wdat is captured once per address on entry to W_SETUP; the source advances on ready and must present the next value before the next W_SETUP entry.
REQ-019 Read access takes 3 clocks per address. R_ADDR: SRAM_ADDR=counter, CE_N=0, OE_N=0, WE_N=1, DQ high-Z. R_WAIT: strobes held. R_SAMPLE: rdat holds SRAM_DQ registered at the end of R_WAIT; ready=1.
REQ-020 rdat holds its value until the next R_SAMPLE; it is not cleared between sweeps.
REQ-021 After W_HOLD/R_SAMPLE: counter < all-ones -> counter+1, back to W_SETUP/R_ADDR; counter = all-ones -> DONE, no wrap access.
REQ-022 DONE lasts 1 clock: stop=1, CE_N=OE_N=WE_N=1, DQ high-Z; next state IDLE.
REQ-023 Full sweep from start-sample to stop is exactly 3*2**SRAM_ADDR_SIZE+1 clocks after the start cycle; ready pulses exactly 2**SRAM_ADDR_SIZE times, never coincident with stop.
REQ-024 Counter is SRAM_ADDR_SIZE bits, increments modulo 2**SRAM_ADDR_SIZE; no stuck or skipped addresses.
REQ-025 DQ is never driven while OE_N=0; turnaround between write and read sweeps passes through DONE and IDLE, so at least 2 idle clocks elapse.
REQ-026 start asserted in the DONE cycle is ignored; start asserted in the IDLE cycle directly after DONE is accepted.

Reset
REQ-027 rst_n=0 forces immediately, from any state: state IDLE, ready=0, stop=0, CE_N=OE_N=WE_N=1, DQ high-Z, SRAM_ADDR=0, counter=0, rdat=0.
REQ-028 Reset mid-sweep aborts without a stop pulse; the first start after release begins a fresh sweep at address 0.

Verification (bench uses SRAM_ADDR_SIZE=3 with behavioural SRAM model)
REQ-029 Write sweep: start=1, rnw=0, wdat from counter 0xA0+n advanced on ready -> 8 WE_N low pulses at addresses 0..7, memory holds A0..A7, stop 25 clocks after start.
REQ-030 Read sweep after REQ-029: start=1, rnw=1 -> 8 ready pulses with rdat=A0..A7 in order, stop one clock after the 8th ready.
REQ-031 start pulsed repeatedly during a write sweep -> no restart, address sequence 0..7 unchanged, exactly one stop.
REQ-032 rst_n low during W_PULSE at address 4 -> strobes inactive and DQ high-Z in the same cycle, no stop; next read sweep begins at address 0.
REQ-033 start held high continuously with rnw=1 -> back-to-back sweeps, each 25 clocks start-to-stop, one IDLE clock between DONE and the next R_ADDR.
REQ-034 Throughout all scenarios, assert that DQ is never driven while OE_N=0 and that ready and stop are never high together.
